// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage with valid/ready load and back-to-back frames
// Optional trailing even-parity bit per frame when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done
);

`ifdef PISO_PARITY_EN
    localparam int SW   = WIDTH + 1;
    localparam int LAST = WIDTH;
`else
    localparam int SW   = WIDTH;
    localparam int LAST = WIDTH - 1;
`endif
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [SW-1:0] load_word;
    logic [SW-1:0] shifted;
    logic          head;
    logic          last_bit;
    logic          transfer;

    // The parity bit sits at the tail end so it leaves after the data bits.
    always_comb begin
`ifdef PISO_PARITY_EN
        if (MSB_FIRST) load_word = {load_data, ^load_data};
        else           load_word = {^load_data, load_data};
`else
        load_word = load_data;
`endif
    end

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shift_q[SW-2:0], 1'b0};
            head    = shift_q[SW-1];
        end else begin
            shifted = {1'b0, shift_q[SW-1:1]};
            head    = shift_q[0];
        end
    end

    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign load_ready = (state_q == IDLE) || last_bit;
    assign transfer   = load_valid && load_ready;
    assign ser_valid  = (state_q == SHIFT);
    assign ser_out    = (state_q == SHIFT) && head;
    assign frame_done = last_bit;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = SHIFT;
                    shift_d = load_word;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (transfer) begin
                        shift_d = load_word;
                    end else begin
                        state_d = IDLE;
                        shift_d = '0;
                    end
                end else begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer (MSB- and LSB-first)
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
    localparam logic [FL-1:0] EXP_B0   = 9'b1011_0000_1;
    localparam logic [FL-1:0] EXP_0B   = 9'b0000_1011_1;
    localparam logic [FL-1:0] EXP_FF   = 9'b1111_1111_0;
    localparam logic [FL-1:0] EXP_0D_L = 9'b1011_0000_1;
    localparam logic [FL-1:0] EXP_C0   = 9'b1100_0000_0;
`else
    localparam int FL = 8;
    localparam logic [FL-1:0] EXP_B0   = 8'b1011_0000;
    localparam logic [FL-1:0] EXP_0B   = 8'b0000_1011;
    localparam logic [FL-1:0] EXP_FF   = 8'b1111_1111;
    localparam logic [FL-1:0] EXP_0D_L = 8'b1011_0000;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] m_data, l_data;
    logic       m_valid, l_valid;
    logic       m_ready, m_ser, m_sv, m_fd;
    logic       l_ready, l_ser, l_sv, l_fd;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .load_data(m_data), .load_valid(m_valid),
        .load_ready(m_ready), .ser_out(m_ser), .ser_valid(m_sv), .frame_done(m_fd)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .load_data(l_data), .load_valid(l_valid),
        .load_ready(l_ready), .ser_out(l_ser), .ser_valid(l_sv), .frame_done(l_fd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed bundle is {ser_valid, ser_out, frame_done, load_ready}.
    task automatic test_reset();
        rst_n = 1'b0; m_valid = 1'b0; l_valid = 1'b0; m_data = 8'h00; l_data = 8'h00;
        #2;
        n_cmp++;
        if ({m_sv, m_ser, m_fd, m_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL reset_msb got=%b exp=0001", {m_sv, m_ser, m_fd, m_ready});
        end
        n_cmp++;
        if ({l_sv, l_ser, l_fd, l_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL reset_lsb got=%b exp=0001", {l_sv, l_ser, l_fd, l_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_frame();
        m_data = 8'hFF; m_valid = 1'b1;
        step();
        m_valid = 1'b0;
        step(); step(); step();
        n_cmp++;
        if (m_sv !== 1'b1) begin
            n_fail++; $display("FAIL midframe_active got=%b exp=1", m_sv);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_sv, m_ser, m_fd, m_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL midframe_async got=%b exp=0001", {m_sv, m_ser, m_fd, m_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FL + 2; i++) begin
            step();
            n_cmp++;
            if ({m_sv, m_ser, m_fd, m_ready} !== 4'b0001) begin
                n_fail++;
                $display("FAIL midframe_after_release cyc=%0d got=%b exp=0001", i, {m_sv, m_ser, m_fd, m_ready});
            end
        end
    endtask

    task automatic test_single_msb(input logic [7:0] word, input logic [FL-1:0] exp_bits, input string tag);
        logic [3:0] exp;
        m_data = word; m_valid = 1'b1;
        n_cmp++;
        if (m_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_ready_idle got=%b exp=1", tag, m_ready);
        end
        step();
        m_valid = 1'b0; m_data = 8'h00;
        for (int i = 0; i < FL; i++) begin
            exp = {1'b1, exp_bits[FL-1-i], (i == FL - 1), (i == FL - 1)};
            n_cmp++;
            if ({m_sv, m_ser, m_fd, m_ready} !== exp) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", tag, i + 1, {m_sv, m_ser, m_fd, m_ready}, exp);
            end
            step();
        end
        n_cmp++;
        if ({m_sv, m_ser, m_fd, m_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL %s_idle got=%b exp=0001", tag, {m_sv, m_ser, m_fd, m_ready});
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2*FL-1:0] bits;
        logic [3:0]      exp;
        logic            edge_cyc;
        bits = {EXP_B0, EXP_0B};
        m_data = 8'hB0; m_valid = 1'b1;
        step();
        m_data = 8'h0B;
        for (int i = 0; i < 2 * FL; i++) begin
            if (i == FL) m_valid = 1'b0;
            edge_cyc = (i == FL - 1) || (i == 2 * FL - 1);
            exp = {1'b1, bits[2*FL-1-i], edge_cyc, edge_cyc};
            n_cmp++;
            if ({m_sv, m_ser, m_fd, m_ready} !== exp) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", i + 1, {m_sv, m_ser, m_fd, m_ready}, exp);
            end
            step();
        end
        n_cmp++;
        if ({m_sv, m_ser, m_fd, m_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL b2b_idle got=%b exp=0001", {m_sv, m_ser, m_fd, m_ready});
        end
        step();
    endtask

    task automatic test_ignored_load();
        logic [2*FL-1:0] bits;
        logic [3:0]      exp;
        logic            edge_cyc;
        bits = {EXP_B0, EXP_FF};
        m_data = 8'hB0; m_valid = 1'b1;
        step();
        m_valid = 1'b0; m_data = 8'h00;
        for (int i = 0; i < 2 * FL; i++) begin
            if (i == 3) begin
                m_valid = 1'b1; m_data = 8'hFF;
            end
            if (i == FL) m_valid = 1'b0;
            edge_cyc = (i == FL - 1) || (i == 2 * FL - 1);
            exp = {1'b1, bits[2*FL-1-i], edge_cyc, edge_cyc};
            n_cmp++;
            if ({m_sv, m_ser, m_fd, m_ready} !== exp) begin
                n_fail++;
                $display("FAIL ignored_load cyc=%0d got=%b exp=%b", i + 1, {m_sv, m_ser, m_fd, m_ready}, exp);
            end
            step();
        end
        n_cmp++;
        if (m_sv !== 1'b0) begin
            n_fail++; $display("FAIL ignored_load_idle got=%b exp=0", m_sv);
        end
        step();
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp;
        l_data = 8'h0D; l_valid = 1'b1;
        step();
        l_valid = 1'b0; l_data = 8'h00;
        for (int i = 0; i < FL; i++) begin
            exp = {1'b1, EXP_0D_L[FL-1-i], (i == FL - 1), (i == FL - 1)};
            n_cmp++;
            if ({l_sv, l_ser, l_fd, l_ready} !== exp) begin
                n_fail++;
                $display("FAIL lsb_first cyc=%0d got=%b exp=%b", i + 1, {l_sv, l_ser, l_fd, l_ready}, exp);
            end
            step();
        end
        n_cmp++;
        if ({l_sv, l_ser, l_fd, l_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL lsb_idle got=%b exp=0001", {l_sv, l_ser, l_fd, l_ready});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_single_msb(8'hB0, EXP_B0, "single_b0");
        test_back_to_back();
        test_ignored_load();
        test_lsb_first();
`ifdef PISO_PARITY_EN
        test_single_msb(8'hC0, EXP_C0, "parity_c0");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
